// File: rtl/panda_pkg.sv
// Shared types for the Panda core execute stage.
package panda_pkg;

   // RV32M divide/remainder operation select
   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_operator_e;

   // Iterative divider control states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } div_state_e;

endpackage

// File: rtl/panda_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish early.
module panda_divider
   import panda_pkg::*;
#(
   parameter int unsigned Width = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  div_operator_e        operator_i,
   input  logic [Width-1:0]     operand_a_i,
   input  logic [Width-1:0]     operand_b_i,
   input  logic                 kill_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [Width-1:0]     result_o
);

   localparam int unsigned CntW = $clog2(Width);

   // Two's-complement negate when requested; used for magnitudes and final sign fix
   function automatic logic [Width-1:0] sign_fix(input logic [Width-1:0] v, input logic neg);
      sign_fix = neg ? (~v + Width'(1)) : v;
   endfunction

   div_state_e          state_q, state_d;
   div_operator_e       op_q;
   logic [Width-1:0]    quo_q;      // dividend shift register, fills with quotient bits
   logic [Width-1:0]    rem_q;      // partial remainder (always < divisor, so Width bits suffice)
   logic [Width-1:0]    dvs_q;      // divisor magnitude
   logic [CntW-1:0]     cnt_q;
   logic                neg_quo_q;
   logic                neg_rem_q;

   logic                accept;
   logic                in_signed;
   logic                in_div_zero;
   logic                in_overflow;
   logic                in_special;
   logic                a_neg;
   logic                b_neg;
   logic [Width:0]      r_shift;
   logic [Width:0]      r_diff;
   logic                is_rem;
   logic [Width-1:0]    res_fix;

   // Request qualification and early-out detection on the incoming operands
   assign accept      = (state_q == IDLE) && valid_i && !kill_i;
   assign in_signed   = (operator_i == DIV) || (operator_i == REM);
   assign in_div_zero = (operand_b_i == '0);
   assign in_overflow = in_signed &&
                        (operand_a_i == {1'b1, {(Width-1){1'b0}}}) &&
                        (operand_b_i == '1);
   assign in_special  = in_div_zero || in_overflow;
   assign a_neg       = in_signed && operand_a_i[Width-1];
   assign b_neg       = in_signed && operand_b_i[Width-1];

   // One restoring step: shift in next dividend bit, trial-subtract divisor
   assign r_shift = {rem_q, quo_q[Width-1]};
   assign r_diff  = r_shift - {1'b0, dvs_q};

   // Final result select with sign correction
   assign is_rem  = (op_q == REM) || (op_q == REMU);
   assign res_fix = is_rem ? sign_fix(rem_q, neg_rem_q) : sign_fix(quo_q, neg_quo_q);

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d  = state_q;
      ready_o  = 1'b0;
      valid_o  = 1'b0;
      result_o = '0;
      unique case (state_q)
         IDLE: begin
            ready_o = 1'b1;
            if (accept) begin
               state_d = in_special ? DONE : CALC;
            end
         end
         CALC: begin
            if (kill_i) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            valid_o  = 1'b1;
            result_o = res_fix;
            if (kill_i || ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand load on acceptance, one shift/subtract step per CALC cycle
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q      <= DIV;
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else if (accept) begin
         op_q  <= operator_i;
         dvs_q <= sign_fix(operand_b_i, b_neg);
         cnt_q <= CntW'(Width - 1);
         if (in_div_zero) begin
            quo_q     <= '1;
            rem_q     <= operand_a_i;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
         end else if (in_overflow) begin
            quo_q     <= operand_a_i;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
         end else begin
            quo_q     <= sign_fix(operand_a_i, a_neg);
            rem_q     <= '0;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
         end
      end else if (state_q == CALC) begin
         if (!r_diff[Width]) begin
            rem_q <= r_diff[Width-1:0];
            quo_q <= {quo_q[Width-2:0], 1'b1};
         end else begin
            rem_q <= r_shift[Width-1:0];
            quo_q <= {quo_q[Width-2:0], 1'b0};
         end
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
         end
      end
   end

endmodule

// File: tb/tb_panda_divider.sv
// Self-checking bench for panda_divider: scoreboard of expected results.
module tb_panda_divider;
   import panda_pkg::*;

   localparam int unsigned W       = 32;
   localparam int          TIMEOUT = 64;

   logic          clk;
   logic          rst_i;
   logic          valid_i;
   logic          ready_o;
   div_operator_e operator_i;
   logic [W-1:0]  operand_a_i;
   logic [W-1:0]  operand_b_i;
   logic          kill_i;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  result_o;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];

   panda_divider #(.Width(W)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .operator_i  (operator_i),
      .operand_a_i (operand_a_i),
      .operand_b_i (operand_b_i),
      .kill_i      (kill_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .result_o    (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of RV32M divide semantics
   function automatic logic [W-1:0] ref_result(input div_operator_e op,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
      logic is_signed;
      logic is_div;
      is_signed = (op == DIV) || (op == REM);
      is_div    = (op == DIV) || (op == DIVU);
      if (b == 0) return is_div ? 32'hFFFF_FFFF : a;
      if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_div ? a : 32'h0;
      case (op)
         DIV:     return $signed(a) / $signed(b);
         REM:     return $signed(a) % $signed(b);
         DIVU:    return a / b;
         default: return a % b;
      endcase
   endfunction

   function automatic int ref_latency(input div_operator_e op, input logic [W-1:0] a,
                                      input logic [W-1:0] b);
      if (b == 0) return 0;
      if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return W;
   endfunction

   // Present one request for a single edge and record its expected result
   task automatic issue(input div_operator_e op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
      @(negedge clk);
      valid_i     = 1'b1;
      operator_i  = op;
      operand_a_i = a;
      operand_b_i = b;
      exp_q.push_back(exp);
      @(negedge clk);
      valid_i = 1'b0;
   endtask

   // Count edges after the accept edge until valid_o is seen (bounded)
   task automatic wait_valid(output int n);
      n = 0;
      while (valid_o !== 1'b1 && n < TIMEOUT) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
   endtask

   task automatic take_result();
      ready_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
         failures++;
         $display("FAIL reset_in: ready=%b valid=%b result=%h expected 1 0 0", ready_o, valid_o, result_o);
      end
      rst_i = 1'b0;
      @(negedge clk);
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
         failures++;
         $display("FAIL reset_out: ready=%b valid=%b result=%h expected 1 0 0", ready_o, valid_o, result_o);
      end
   endtask

   task automatic test_directed();
      div_operator_e ops[10] = '{DIVU, REMU, DIV, REM, DIV, REM, DIVU, REM, DIV, REM};
      logic [W-1:0] av[10] = '{32'd100, 32'd100, 32'hFFFF_FFC2, 32'hFFFF_FFC2, 32'd30,
                               32'hFFFF_FFDD, 32'd30, 32'd30, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] bv[10] = '{32'd7, 32'd7, 32'd5, 32'd5, 32'hFFFF_FFFD,
                               32'hFFFF_FF9F, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] ev[10] = '{32'd14, 32'd2, 32'hFFFF_FFF4, 32'hFFFF_FFFE, 32'hFFFF_FFF6,
                               32'hFFFF_FFDD, 32'hFFFF_FFFF, 32'd30, 32'h8000_0000, 32'd0};
      int lv[10] = '{32, 32, 32, 32, 32, 32, 0, 0, 0, 0};
      int n;
      logic [W-1:0] exp;
      for (int i = 0; i < 10; i++) begin
         issue(ops[i], av[i], bv[i], ev[i]);
         wait_valid(n);
         checks++;
         if (n != lv[i]) begin
            failures++;
            $display("FAIL directed_latency[%0d]: got %0d edges expected %0d", i, n, lv[i]);
         end
         exp = exp_q.pop_front();
         checks++;
         if (result_o !== exp) begin
            failures++;
            $display("FAIL directed_result[%0d]: got %h expected %h", i, result_o, exp);
         end
         take_result();
         checks++;
         if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
            failures++;
            $display("FAIL directed_idle[%0d]: ready=%b valid=%b result=%h expected 1 0 0",
                     i, ready_o, valid_o, result_o);
         end
      end
   endtask

   task automatic test_backpressure();
      int n;
      int bad;
      logic [W-1:0] held;
      logic [W-1:0] exp;
      issue(DIVU, 32'd1000, 32'd3, 32'd333);
      wait_valid(n);
      held = result_o;
      bad  = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== held) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL backpressure_hold: %0d unstable cycles expected 0", bad);
      end
      exp = exp_q.pop_front();
      checks++;
      if (result_o !== exp) begin
         failures++;
         $display("FAIL backpressure_result: got %h expected %h", result_o, exp);
      end
      take_result();
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL backpressure_release: ready=%b valid=%b expected 1 0", ready_o, valid_o);
      end
   endtask

   task automatic test_kill();
      int n;
      int seen;
      logic [W-1:0] exp;
      // Kill presented with a request in IDLE blocks acceptance
      @(negedge clk);
      valid_i = 1'b1; kill_i = 1'b1;
      operator_i = DIVU; operand_a_i = 32'd5; operand_b_i = 32'd1;
      @(negedge clk);
      valid_i = 1'b0; kill_i = 1'b0;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL kill_idle: ready=%b valid=%b expected 1 0", ready_o, valid_o);
      end
      // Kill at CALC step 10
      issue(DIVU, 32'h1234_5678, 32'd3, ref_result(DIVU, 32'h1234_5678, 32'd3));
      repeat (9) @(negedge clk);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      void'(exp_q.pop_front());
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
         failures++;
         $display("FAIL kill_calc: ready=%b valid=%b expected 1 0", ready_o, valid_o);
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (valid_o === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL kill_no_result: valid seen %0d cycles expected 0", seen);
      end
      issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      wait_valid(n);
      checks++;
      if (n != W) begin
         failures++;
         $display("FAIL kill_followup_latency: got %0d expected %0d", n, W);
      end
      exp = exp_q.pop_front();
      checks++;
      if (result_o !== exp) begin
         failures++;
         $display("FAIL kill_followup_result: got %h expected %h", result_o, exp);
      end
      take_result();
   endtask

   task automatic test_reset_mid();
      int n;
      logic [W-1:0] exp;
      // Reset mid-CALC
      issue(DIVU, 32'd500, 32'd4, 32'd125);
      repeat (5) @(negedge clk);
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
         failures++;
         $display("FAIL reset_calc: ready=%b valid=%b result=%h expected 1 0 0", ready_o, valid_o, result_o);
      end
      @(negedge clk);
      rst_i = 1'b0;
      void'(exp_q.pop_front());
      // Reset mid-DONE
      issue(REMU, 32'd9, 32'd0, 32'd9);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (valid_o !== 1'b1 || result_o !== exp) begin
         failures++;
         $display("FAIL reset_done_pre: valid=%b result=%h expected 1 %h", valid_o, result_o, exp);
      end
      #2 rst_i = 1'b1;
      #1;
      checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || result_o !== '0) begin
         failures++;
         $display("FAIL reset_done: ready=%b valid=%b result=%h expected 1 0 0", ready_o, valid_o, result_o);
      end
      @(negedge clk);
      rst_i = 1'b0;
      issue(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
      wait_valid(n);
      exp = exp_q.pop_front();
      checks++;
      if (n != W || result_o !== exp) begin
         failures++;
         $display("FAIL reset_followup: got %h after %0d edges expected %h after %0d", result_o, n, exp, W);
      end
      take_result();
   endtask

   task automatic test_random();
      div_operator_e op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      int n;
      int lat;
      for (int i = 0; i < 24; i++) begin
         op = div_operator_e'($urandom_range(0, 3));
         a  = $urandom;
         b  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
         if ($urandom_range(0, 1) == 1) b = -b;
         if (i == 5) b = '0;
         lat = ref_latency(op, a, b);
         issue(op, a, b, ref_result(op, a, b));
         wait_valid(n);
         exp = exp_q.pop_front();
         checks++;
         if (n != lat || result_o !== exp) begin
            failures++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h after %0d edges expected %h after %0d",
                     i, op, a, b, result_o, n, exp, lat);
         end
         take_result();
      end
   endtask

   initial begin
      rst_i       = 1'b0;
      valid_i     = 1'b0;
      operator_i  = DIV;
      operand_a_i = '0;
      operand_b_i = '0;
      kill_i      = 1'b0;
      ready_i     = 1'b0;
      test_reset();
      test_directed();
      test_backpressure();
      test_kill();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
